// File: rtl/pixel_raster_binarizer_pkg.sv
// Shared raster definitions for the binarizer front end: default frame geometry,
// pixel/coordinate widths and the raster FSM state encoding.
package pixel_raster_binarizer_pkg;

  localparam int FRAME_W_DEF = 640;
  localparam int FRAME_H_DEF = 480;
  localparam int PIX_W_DEF   = 10;
  localparam int COORD_W_DEF = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } raster_state_t;

endpackage

// File: rtl/pixel_raster_binarizer_frame_mean_acc.sv
// Per-frame gray accumulator and mean-threshold latch (built only with ADAPTIVE_THRESHOLD_EN).
// Until the first complete frame has been averaged, the static threshold passes through.
module pixel_raster_binarizer_frame_mean_acc
  import pixel_raster_binarizer_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int PIXELS = FRAME_W_DEF * FRAME_H_DEF
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic             frame_sync,
  input  logic             accept,
  input  logic             last,
  input  logic [PIX_W-1:0] gray,
  input  logic [PIX_W-1:0] threshold_q,
  output logic [PIX_W-1:0] thr
);

  // Rounded-up reciprocal with 32 + log2(N) fraction bits gives an exact floor for any 32-bit sum.
  localparam int          SHIFT = 32 + $clog2(PIXELS);
  localparam logic [71:0] RECIP = ((72'd1 << SHIFT) + 72'(PIXELS) - 72'd1) / 72'(PIXELS);

  logic [31:0]      sum_q;
  logic [31:0]      sum_base;
  logic [31:0]      sum_next;
  logic [PIX_W-1:0] mean_q;
  logic [PIX_W-1:0] mean_next;
  logic             have_mean;

  always_comb begin
    sum_base  = frame_sync ? 32'd0 : sum_q;
    sum_next  = sum_base + 32'(gray);
    mean_next = PIX_W'((72'(sum_next) * RECIP) >> SHIFT);
  end

  // A frame restarted by frame_sync never reaches 'last', so short frames leave the mean untouched.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      sum_q     <= '0;
      mean_q    <= '0;
      have_mean <= 1'b0;
    end else begin
      if (accept) begin
        sum_q <= sum_next;
      end else if (frame_sync) begin
        sum_q <= '0;
      end
      if (accept && last) begin
        mean_q    <= mean_next;
        have_mean <= 1'b1;
      end
    end
  end

  assign thr = have_mean ? mean_q : threshold_q;

endmodule

// File: rtl/pixel_raster_binarizer.sv
// Raster counters, frame framing and threshold decision feeding the linear classifier.
// Define ADAPTIVE_THRESHOLD_EN to replace the static threshold with the previous frame's mean.
module pixel_raster_binarizer
  import pixel_raster_binarizer_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               frame_sync,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   gray,
  input  logic [PIX_W-1:0]   threshold,
  output logic [COORD_W-1:0] true_x,
  output logic [COORD_W-1:0] true_y,
  output logic [PIX_W-1:0]   binarized_value,
  output logic               pix_out_valid,
  output logic               frame_done,
  output logic               short_frame,
  output logic [15:0]        frame_count
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_H - 1);

  raster_state_t      state_q;
  raster_state_t      state_next;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic [COORD_W-1:0] eff_x;
  logic [COORD_W-1:0] eff_y;
  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic               in_frame;
  logic               pix_accept;
  logic               pix_last;
  logic [PIX_W-1:0]   thr_reg;
  logic [PIX_W-1:0]   thr;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // frame_sync takes effect before a pixel in the same cycle, so that pixel lands at (0,0).
  always_comb begin
    state_next = state_q;
    eff_x      = frame_sync ? '0 : x_cnt;
    eff_y      = frame_sync ? '0 : y_cnt;
    in_frame   = frame_sync || (state_q == ACTIVE);
    pix_accept = pix_valid && in_frame;
    pix_last   = pix_accept && (eff_x == X_LAST) && (eff_y == Y_LAST);
    x_next     = eff_x;
    y_next     = eff_y;
    if (pix_accept) begin
      if (eff_x == X_LAST) begin
        x_next = '0;
        y_next = (eff_y == Y_LAST) ? '0 : eff_y + 1'b1;
      end else begin
        x_next = eff_x + 1'b1;
      end
    end
    case (state_q)
      IDLE, DONE: begin
        if (frame_sync) begin
          state_next = pix_last ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (pix_last) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      thr_reg     <= '0;
      short_frame <= 1'b0;
      frame_count <= '0;
    end else begin
      x_cnt   <= x_next;
      y_cnt   <= y_next;
      thr_reg <= threshold;
      if (frame_sync && (state_q == ACTIVE)) begin
        short_frame <= 1'b1;
      end
      if (pix_last) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

`ifdef ADAPTIVE_THRESHOLD_EN
  pixel_raster_binarizer_frame_mean_acc #(
    .PIX_W  (PIX_W),
    .PIXELS (FRAME_W * FRAME_H)
  ) u_mean_acc (
    .clock_50    (clock_50),
    .reset       (reset),
    .frame_sync  (frame_sync),
    .accept      (pix_accept),
    .last        (pix_last),
    .gray        (gray),
    .threshold_q (thr_reg),
    .thr         (thr)
  );
`else
  assign thr = thr_reg;
`endif

  // Idle cycles drive a zero value because the classifier accumulates on every clock.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      true_x          <= '0;
      true_y          <= '0;
      binarized_value <= '0;
      pix_out_valid   <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      pix_out_valid <= pix_accept;
      frame_done    <= pix_last;
      if (pix_accept) begin
        true_x          <= eff_x;
        true_y          <= eff_y;
        binarized_value <= {PIX_W{gray >= thr}};
      end else begin
        binarized_value <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_raster_binarizer.sv
// Directed scoreboard bench for pixel_raster_binarizer on a 4x3 frame; a behavioural model
// pushes the expected output per driven cycle, popped and compared one clock later.
module tb_pixel_raster_binarizer;

  localparam int FW = 4;
  localparam int FH = 3;
`ifdef ADAPTIVE_THRESHOLD_EN
  localparam bit ADAPT = 1'b1;
`else
  localparam bit ADAPT = 1'b0;
`endif

  logic        clock_50;
  logic        reset;
  logic        frame_sync;
  logic        pix_valid;
  logic [9:0]  gray;
  logic [9:0]  threshold;
  logic [12:0] true_x;
  logic [12:0] true_y;
  logic [9:0]  binarized_value;
  logic        pix_out_valid;
  logic        frame_done;
  logic        short_frame;
  logic [15:0] frame_count;

  typedef struct {
    logic        valid;
    logic [12:0] x;
    logic [12:0] y;
    logic [9:0]  bin;
    logic        done;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;

  int m_state;
  int m_x;
  int m_y;
  int m_tx;
  int m_ty;
  int m_cnt;
  int m_short;
  int m_sum;
  int m_mean;
  bit m_have;

  pixel_raster_binarizer #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .PIX_W   (10),
    .COORD_W (13)
  ) dut (
    .clock_50        (clock_50),
    .reset           (reset),
    .frame_sync      (frame_sync),
    .pix_valid       (pix_valid),
    .gray            (gray),
    .threshold       (threshold),
    .true_x          (true_x),
    .true_y          (true_y),
    .binarized_value (binarized_value),
    .pix_out_valid   (pix_out_valid),
    .frame_done      (frame_done),
    .short_frame     (short_frame),
    .frame_count     (frame_count)
  );

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_x     = 0;
    m_y     = 0;
    m_tx    = 0;
    m_ty    = 0;
    m_cnt   = 0;
    m_short = 0;
    m_sum   = 0;
    m_mean  = 0;
    m_have  = 1'b0;
    sb.delete();
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, "_valid"}, 32'(pix_out_valid), 32'd0);
    checkVal({tag, "_x"}, 32'(true_x), 32'd0);
    checkVal({tag, "_y"}, 32'(true_y), 32'd0);
    checkVal({tag, "_bin"}, 32'(binarized_value), 32'd0);
    checkVal({tag, "_done"}, 32'(frame_done), 32'd0);
    checkVal({tag, "_short"}, 32'(short_frame), 32'd0);
    checkVal({tag, "_count"}, 32'(frame_count), 32'd0);
  endtask

  task automatic checkOutput();
    exp_t e;
    checkVal("sb_entry", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkVal("pix_out_valid", 32'(pix_out_valid), 32'(e.valid));
      checkVal("true_x", 32'(true_x), 32'(e.x));
      checkVal("true_y", 32'(true_y), 32'(e.y));
      checkVal("binarized_value", 32'(binarized_value), 32'(e.bin));
      checkVal("frame_done", 32'(frame_done), 32'(e.done));
    end
    checkVal("frame_count", 32'(frame_count), 32'(m_cnt & 16'hFFFF));
    checkVal("short_frame", 32'(short_frame), 32'(m_short));
    if (frame_done === 1'b1) done_seen++;
  endtask

  task automatic applyStimulus(input logic fs, input logic pv, input logic [9:0] g);
    exp_t e;
    int   thr_eff;
    bit   act;
    @(negedge clock_50);
    frame_sync = fs;
    pix_valid  = pv;
    gray       = g;
    thr_eff = (ADAPT && m_have) ? m_mean : int'(threshold);
    act = fs || (m_state == 1);
    if (fs) begin
      if (m_state == 1) m_short = 1;
      m_state = 1;
      m_x     = 0;
      m_y     = 0;
      m_sum   = 0;
    end
    e.valid = 1'b0;
    e.bin   = 10'h000;
    e.done  = 1'b0;
    if (pv && act) begin
      e.valid = 1'b1;
      m_tx    = m_x;
      m_ty    = m_y;
      e.bin   = (int'(g) >= thr_eff) ? 10'h3FF : 10'h000;
      m_sum   = m_sum + int'(g);
      if (m_x == FW - 1 && m_y == FH - 1) begin
        e.done  = 1'b1;
        m_state = 2;
        m_cnt++;
        m_x = 0;
        m_y = 0;
        if (ADAPT) begin
          m_mean = m_sum / (FW * FH);
          m_have = 1'b1;
        end
      end else if (m_x == FW - 1) begin
        m_x = 0;
        m_y++;
      end else begin
        m_x++;
      end
    end
    e.x = 13'(m_tx);
    e.y = 13'(m_ty);
    sb.push_back(e);
    @(posedge clock_50);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clock_50);
    reset      = 1'b1;
    frame_sync = 1'b0;
    pix_valid  = 1'b0;
    gray       = '0;
    modelReset();
    #1;
    checkZero("reset");
    @(negedge clock_50);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 10'd0);
    applyStimulus(1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    reset      = 1'b0;
    frame_sync = 1'b0;
    pix_valid  = 1'b0;
    gray       = '0;
    threshold  = 10'd400;
    modelReset();

    $display("[TB] test 1: full frame, gray ramp");
    doReset();
    done_seen = 0;
    applyStimulus(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < FW * FH; i++) applyStimulus(1'b0, 1'b1, 10'(i * 80));
    applyStimulus(1'b0, 1'b0, 10'd0);
    checkVal("t1_done_pulses", 32'(done_seen), 32'd1);
    checkVal("t1_frame_count", 32'(frame_count), 32'd1);

    $display("[TB] test 4: frame_sync with pixel in DONE");
    applyStimulus(1'b1, 1'b1, 10'd500);
    checkVal("t4_x", 32'(true_x), 32'd0);
    checkVal("t4_y", 32'(true_y), 32'd0);
    checkVal("t4_valid", 32'(pix_out_valid), 32'd1);

    $display("[TB] test 2: gapped pixels");
    doReset();
    applyStimulus(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < FW * FH; i++) begin
      applyStimulus(1'b0, 1'b1, 10'((i * 173) % 1024));
      applyStimulus(1'b0, 1'b0, 10'd1023);
    end
    checkVal("t2_frame_count", 32'(frame_count), 32'd1);

    $display("[TB] test 3: short frame");
    doReset();
    applyStimulus(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 10'(100 * i));
    applyStimulus(1'b1, 1'b0, 10'd0);
    checkVal("t3_short", 32'(short_frame), 32'd1);
    checkVal("t3_count_kept", 32'(frame_count), 32'd0);
    applyStimulus(1'b0, 1'b1, 10'd600);
    checkVal("t3_restart_x", 32'(true_x), 32'd0);
    checkVal("t3_restart_y", 32'(true_y), 32'd0);
    for (int i = 1; i < FW * FH; i++) applyStimulus(1'b0, 1'b1, 10'(50 * i));
    checkVal("t3_frame_count", 32'(frame_count), 32'd1);

    $display("[TB] test 5: reset mid-frame");
    doReset();
    applyStimulus(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 10'd800);
    checkVal("t5_at_x", 32'(true_x), 32'd2);
    checkVal("t5_at_y", 32'(true_y), 32'd1);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkZero("t5_midreset");
    @(negedge clock_50);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 10'd900);
    checkVal("t5_no_output", 32'(pix_out_valid), 32'd0);

`ifdef ADAPTIVE_THRESHOLD_EN
    $display("[TB] test 6: adaptive threshold");
    threshold = 10'd900;
    doReset();
    applyStimulus(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < FW * FH; i++) applyStimulus(1'b0, 1'b1, 10'd200);
    checkVal("t6_frame1_bin", 32'(binarized_value), 32'd0);
    applyStimulus(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < FW * FH; i++) applyStimulus(1'b0, 1'b1, 10'd200);
    checkVal("t6_frame2_bin", 32'(binarized_value), 32'h3FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
